// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - March C- BIST types, element tables and pattern constants
package ram_bist_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_CMP,
    ST_DONE
  } bist_state_e;

  // March C- elements in execution order
  typedef enum logic [2:0] {
    E0,
    E1,
    E2,
    E3,
    E4,
    E5
  } march_elem_e;

  // Data patterns as a single bit, replicated across the data word by the user
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // Address direction of each element: 1 = down (DEPTH-1 to 0)
  function automatic logic elem_down(input march_elem_e e);
    case (e)
      E3, E4, E5: elem_down = 1'b1;
      default:    elem_down = 1'b0;
    endcase
  endfunction

  // Pattern every read in the element is expected to return
  function automatic logic elem_rd_pat(input march_elem_e e);
    case (e)
      E2, E4:  elem_rd_pat = P1;
      default: elem_rd_pat = P0;
    endcase
  endfunction

  // Pattern written by the element
  function automatic logic elem_wr_pat(input march_elem_e e);
    case (e)
      E1, E3:  elem_wr_pat = P1;
      default: elem_wr_pat = P0;
    endcase
  endfunction

  // E5 is read-only
  function automatic logic elem_has_write(input march_elem_e e);
    elem_has_write = (e != E5);
  endfunction

  // E0 is write-only
  function automatic logic elem_has_read(input march_elem_e e);
    elem_has_read = (e != E0);
  endfunction

  // Following element; E5 is terminal
  function automatic march_elem_e elem_next(input march_elem_e e);
    case (e)
      E0:      elem_next = E1;
      E1:      elem_next = E2;
      E2:      elem_next = E3;
      E3:      elem_next = E4;
      default: elem_next = E5;
    endcase
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// rtl/ram_bist_addr_gen.sv - Up/down address counter with wrap flag and end-point load
module ram_bist_addr_gen #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              load_top_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] addr_nxt_o,
  output logic              wrap_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // Next address in the current direction and whether stepping would wrap
  always_comb begin
    addr_nxt_o = down_i ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
    wrap_o     = down_i ? (addr_q == '0) : (addr_q == '1);
    if (load_i) begin
      addr_d = {ADDR_W{load_top_i}};
    end else if (step_i) begin
      addr_d = addr_nxt_o;
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register; load wins over step
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/ram_march_bist.sv
// rtl/ram_march_bist.sv - March C- BIST initiator for a single-port RAM
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  // The CMP state assumes read data arrives exactly one cycle after RD
  if (RD_LAT != 1) begin : g_rd_lat_unsupported
  end

  bist_state_e       state_q;
  march_elem_e       elem_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_exp_q;
  logic [DATA_W-1:0] fail_got_q;
  logic              mem_wr_en_q;
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_in_q;

  march_elem_e       load_elem;
  logic [ADDR_W-1:0] start_addr;
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] load_wr_word;
  logic              mismatch;
  logic              ag_load;
  logic              ag_load_top;
  logic              ag_step;
  logic              ag_down;
  logic [ADDR_W-1:0] ag_addr;
  logic [ADDR_W-1:0] ag_addr_nxt;
  logic              ag_wrap;

  ram_bist_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ag_load),
    .load_top_i(ag_load_top),
    .step_i    (ag_step),
    .down_i    (ag_down),
    .addr_o    (ag_addr),
    .addr_nxt_o(ag_addr_nxt),
    .wrap_o    (ag_wrap)
  );

  // Element patterns, comparison and address-counter control
  always_comb begin
    load_elem    = (state_q == ST_IDLE) ? E0 : elem_next(elem_q);
    start_addr   = {ADDR_W{elem_down(load_elem)}};
    exp_word     = {DATA_W{elem_rd_pat(elem_q)}};
    wr_word      = {DATA_W{elem_wr_pat(elem_q)}};
    load_wr_word = {DATA_W{elem_wr_pat(load_elem)}};
    mismatch     = (mem_data_out != exp_word);
    ag_load_top  = elem_down(load_elem);
    ag_down      = elem_down(elem_q);
    ag_load      = 1'b0;
    ag_step      = 1'b0;
    case (state_q)
      ST_IDLE: ag_load = start;
      ST_WR: begin
        ag_load = ag_wrap;
        ag_step = !ag_wrap;
      end
      ST_CMP:  ag_step = !mismatch && !elem_has_write(elem_q) && !ag_wrap;
      default: ;
    endcase
  end

  // Sequencer: every output is registered; RAM strobes default low each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      elem_q        <= E0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_addr_q   <= '0;
      fail_exp_q    <= '0;
      fail_got_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
    end else begin
      done_q        <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q       <= ST_WR;
            elem_q        <= E0;
            busy_q        <= 1'b1;
            pass_q        <= 1'b0;
            fail_addr_q   <= '0;
            fail_exp_q    <= '0;
            fail_got_q    <= '0;
            mem_wr_en_q   <= 1'b1;
            mem_addr_q    <= start_addr;
            mem_data_in_q <= load_wr_word;
          end
        end
        ST_WR: begin
          if (ag_wrap) begin
            // Element finished; every element after E0 opens with a read
            elem_q      <= load_elem;
            state_q     <= ST_RD;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= start_addr;
          end else if (elem_has_read(elem_q)) begin
            state_q     <= ST_RD;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= ag_addr_nxt;
          end else begin
            state_q       <= ST_WR;
            mem_wr_en_q   <= 1'b1;
            mem_addr_q    <= ag_addr_nxt;
            mem_data_in_q <= wr_word;
          end
        end
        ST_RD: begin
          state_q <= ST_CMP;
        end
        ST_CMP: begin
          if (mismatch) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_addr_q <= ag_addr;
            fail_exp_q  <= exp_word;
            fail_got_q  <= mem_data_out;
          end else if (elem_has_write(elem_q)) begin
            state_q       <= ST_WR;
            mem_wr_en_q   <= 1'b1;
            mem_addr_q    <= ag_addr;
            mem_data_in_q <= wr_word;
          end else if (ag_wrap) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else begin
            state_q     <= ST_RD;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= ag_addr_nxt;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_addr   = fail_addr_q;
  assign fail_exp    = fail_exp_q;
  assign fail_got    = fail_got_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;

endmodule
